// File: rtl/ysyx_24100029_ifu_pkg.sv
// Shared types for the IFU prefetcher: FSM state encoding, the FIFO entry
// layout and the reset fetch address.
package ysyx_24100029_ifu_pkg;

  localparam int IFU_ADDR_W = 32;
  localparam int IFU_INST_W = 32;

  localparam logic [IFU_ADDR_W-1:0] RESET_PC  = 32'h8000_0000;
  localparam logic [1:0]            RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_t;

  // FIFO DATA_WIDTH is $bits(fetch_entry_t).
  typedef struct packed {
    logic                  fault;
    logic [IFU_ADDR_W-1:0] pc;
    logic [IFU_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_24100029_ifu_prefetch.sv
// Sequential instruction prefetcher feeding the IFU FIFO, one outstanding read.
// Optional YSYX_24100029_PREFETCH_MISALIGN_CHK_EN faults misaligned PCs without a bus request.
module ysyx_24100029_ifu_prefetch #(
  parameter int                ADDR_W   = ysyx_24100029_ifu_pkg::IFU_ADDR_W,
  parameter int                INST_W   = ysyx_24100029_ifu_pkg::IFU_INST_W,
  parameter int                ENTRY_W  = 1 + ADDR_W + INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ysyx_24100029_ifu_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               arvalid,
  output logic [ADDR_W-1:0]  araddr,
  input  logic               arready,
  input  logic               rvalid,
  input  logic [INST_W-1:0]  rdata,
  input  logic [1:0]         rresp,
  output logic               rready,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [ENTRY_W-1:0] fifo_data_in,
  output logic               fifo_clr
);
  import ysyx_24100029_ifu_pkg::*;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [ADDR_W-1:0]  r_araddr;
  logic               r_kill, w_kill_nxt;
  logic               w_issue;
  logic               w_fault;
  logic [INST_W-1:0]  w_inst;

  // araddr is latched separately so a redirect during REQ can move r_pc
  // without disturbing the address already presented on the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_araddr <= RESET_PC;
      r_kill   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      if (w_issue) r_araddr <= r_pc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = redirect_valid ? redirect_pc : r_pc;
    w_kill_nxt  = r_kill;
    w_issue     = 1'b0;
    w_fault     = 1'b0;
    w_inst      = '0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    fifo_wr_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!redirect_valid && !fifo_full) begin
`ifdef YSYX_24100029_PREFETCH_MISALIGN_CHK_EN
          if (r_pc[1:0] != 2'b00) begin
            fifo_wr_en  = 1'b1;
            w_fault     = 1'b1;
            w_state_nxt = S_HALT;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = S_REQ;
          end
`else
          w_issue     = 1'b1;
          w_state_nxt = S_REQ;
`endif
        end
      end
      S_REQ: begin
        arvalid = 1'b1;
        if (redirect_valid) w_kill_nxt = 1'b1;
        if (arready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        rready = 1'b1;
        if (rvalid) begin
          w_state_nxt = S_IDLE;
          w_kill_nxt  = 1'b0;
          // A stale or same-cycle-redirected response is simply dropped.
          if (!r_kill && !redirect_valid) begin
            fifo_wr_en = 1'b1;
            if (rresp == RESP_OKAY) begin
              w_inst   = rdata;
              w_pc_nxt = r_pc + ADDR_W'(4);
            end else begin
              w_fault     = 1'b1;
              w_state_nxt = S_HALT;
            end
          end
        end else if (redirect_valid) begin
          w_kill_nxt = 1'b1;
        end
      end
      S_HALT: begin
        if (redirect_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign araddr       = r_araddr;
  assign fifo_clr     = redirect_valid;
  assign fifo_data_in = {w_fault, r_pc, w_inst};

endmodule

// File: doc/ysyx_24100029_ifu_prefetch.md
Name: ysyx_24100029_ifu_prefetch

Overview:
Instruction prefetcher sitting directly upstream of the IFU instruction FIFO (ysyx_24100029_fifo). It issues single-beat AXI4-style read requests for sequential PCs and pushes {fault, pc, inst} entries into the FIFO. Redirects from EXU/WBU (branch, trap, mret) restart it at a new PC and flush the FIFO. Maximum one outstanding request, so the FIFO can never overflow.

Parameters:
RESET_PC, 32'h8000_0000, PC fetched first after reset
ADDR_W, 32, PC / araddr width
INST_W, 32, instruction / rdata width
ENTRY_W, 1+ADDR_W+INST_W (65), FIFO entry width = {fault, pc, inst}; drives the FIFO's DATA_WIDTH

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  reset, synchronous, active-low
redirect_valid  in  1  one-cycle redirect strobe
redirect_pc  in  ADDR_W  new fetch PC
arvalid  out  1  read-address valid
araddr  out  ADDR_W  read address (= current pc)
arready  in  1  read-address accepted
rvalid  in  1  read-data valid
rdata  in  INST_W  read data
rresp  in  2  read response; nonzero = bus error
rready  out  1  read-data ready
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO push
fifo_data_in  out  ENTRY_W  {fault, pc, inst}
fifo_clr  out  1  FIFO flush

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, pc=RESET_PC, kill=0. Outputs during/after reset: arvalid=0, rready=0, fifo_wr_en=0, fifo_clr=0 (fifo_clr = redirect_valid, which must be held low in reset). Reset overrides everything, including mid-transaction; the bus master must be reset in the same cycle.
- States: IDLE, REQ, WAIT, HALT.
- IDLE: if !fifo_full and !redirect_valid -> REQ; otherwise stay. arvalid=0, rready=0.
- REQ: arvalid=1, araddr=pc; held stable until arready. On arvalid&arready -> WAIT.
- WAIT: rready=1. On rvalid:
  - kill=0, rresp==0: fifo_wr_en=1, data={0, pc, rdata}, pc<=pc+4 (wraps mod 2^ADDR_W), -> IDLE.
  - kill=0, rresp!=0: fifo_wr_en=1, data={1, pc, 32'h0}, pc unchanged, -> HALT.
  - kill=1: no push, kill<=0, -> IDLE.
- HALT: no requests are issued; only a redirect leaves this state.
- fifo_wr_en and fifo_data_in are combinational from WAIT&rvalid; the FIFO samples them on the same edge. Request issue requires fifo_full==0; at most one response is outstanding, so every push has space.
- Redirect (any state): fifo_clr=redirect_valid (combinational, same cycle); pc<=redirect_pc.
  - In IDLE or HALT: -> IDLE.
  - In REQ: arvalid/araddr stay unchanged until the handshake (AXI stability rule). kill<=1, then continue to WAIT.
  - In WAIT: kill<=1. If rvalid occurs in the same cycle, the response is dropped: no push, kill is not set, -> IDLE.
  - A redirect coinciding with a would-be push always suppresses the push.
- Back-to-back redirects: the last one wins. kill stays 1 until the single outstanding response drains.
- Steady-state throughput is one entry per 3 cycles with zero-wait memory (IDLE -> REQ -> WAIT).

Optional Feature:
- Macro: YSYX_24100029_PREFETCH_MISALIGN_CHK_EN.
- When defined: in IDLE, if pc[1:0]!=0 and !fifo_full, no bus request is issued. Instead, push {1, pc, 32'h0} directly and go to HALT.
- When undefined: pc[1:0] is not checked. araddr carries pc as-is, and misalignment is reported only through rresp.

Decomposition:
- Package ysyx_24100029_ifu_pkg holds:
  - state enum (IDLE/REQ/WAIT/HALT)
  - packed struct fetch_entry_t {fault, pc, inst}
  - RESET_PC localparam
  - RESP_OKAY=2'b00
- The FIFO instantiates with DATA_WIDTH=$bits(fetch_entry_t).
- No sub-module: the FSM plus PC register is a single cohesive block.

Test Plan:
- Release reset, memory with zero wait states returning 32'h0000_0413 at 0x80000000 -> arvalid rises first cycle after release with araddr=0x80000000; push {0, 0x80000000, 0x00000413}; next araddr=0x80000004.
- Hold fifo_full=1 in IDLE for 10 cycles -> arvalid stays 0; drop fifo_full -> arvalid next cycle.
- Redirect to 0x80001000 while in REQ, with arready delayed 3 cycles -> araddr stays 0x8000000x until the handshake; fifo_clr pulses one cycle; response discarded (no push); next request uses araddr=0x80001000.
- Redirect in the same cycle as rvalid -> fifo_wr_en=0, fifo_clr=1; next araddr=redirect_pc.
- rresp=2'b10 at 0x80000008 -> push {1, 0x80000008, 0}; no further arvalid for 20 cycles; redirect to 0x80000100 resumes fetching.
- With YSYX_24100029_PREFETCH_MISALIGN_CHK_EN defined, redirect to 0x80000002 -> no arvalid; push {1, 0x80000002, 0}; enter HALT.
